// File: rtl/led_logic_db.sv
// Switch-to-LED block: per-channel two-flop synchroniser and debouncer, then a
// runtime-selectable OR/AND/XOR/majority combine into a registered LED and change pulse.
module led_logic_db #(
    parameter int N_SW      = 3,
    parameter int DB_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw,
    input  logic [1:0]      mode,
    output logic [N_SW-1:0] sw_db,
    output logic            out,
    output logic            out_chg
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int PW = $clog2(N_SW + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OR  = 2'b00,
        MODE_AND = 2'b01,
        MODE_XOR = 2'b10,
        MODE_MAJ = 2'b11
    } mode_e;

    logic [N_SW-1:0] s1;
    logic [N_SW-1:0] s2;
    logic [CW-1:0]   cnt [N_SW];
    logic [PW-1:0]   pop;
    logic            majority;
    logic            f;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse s1->s2 into a single stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // NOTE: the counter array is small and each entry must start at zero for the
    // stable-window count to be correct, so it is reset along with the other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_db <= '0;
            for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                if (s2[i] == sw_db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    sw_db[i] <= s2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_SW; i++) pop = pop + PW'(sw_db[i]);
        // Strict 2*pop > N_SW: an even-width tie resolves to 0.
        majority = ({pop, 1'b0} > (PW + 1)'(N_SW));
        f = 1'b0;
        case (mode_e'(mode))
            MODE_OR:  f = |sw_db;
            MODE_AND: f = &sw_db;
            MODE_XOR: f = ^sw_db;
            MODE_MAJ: f = majority;
            default:  f = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= 1'b0;
            out_chg <= 1'b0;
        end else begin
            out     <= f;
            out_chg <= (f != out);
        end
    end

endmodule

// File: tb/tb_led_logic_db.sv
// Directed bench for led_logic_db (N_SW=3, DB_CYCLES=4): reset, debounce timing,
// glitch rejection, mode sweep, reset mid-debounce and simultaneous channels.
module tb_led_logic_db;

    localparam int N_SW      = 3;
    localparam int DB_CYCLES = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_SW-1:0] sw;
    logic [1:0]      mode;
    logic [N_SW-1:0] sw_db;
    logic            out;
    logic            out_chg;

    int n_checks = 0;
    int n_fail   = 0;

    led_logic_db #(.N_SW(N_SW), .DB_CYCLES(DB_CYCLES)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .mode    (mode),
        .sw_db   (sw_db),
        .out     (out),
        .out_chg (out_chg)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        sw   = 3'b111;
        mode = 2'b00;
        idle(3);
        n_checks++;
        if (sw_db !== 3'b000) begin n_fail++; $display("FAIL reset_sw_db got=%b want=000", sw_db); end
        n_checks++;
        if (out !== 1'b0) begin n_fail++; $display("FAIL reset_out got=%b want=0", out); end
        n_checks++;
        if (out_chg !== 1'b0) begin n_fail++; $display("FAIL reset_out_chg got=%b want=0", out_chg); end
        sw  = 3'b000;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (out_chg !== 1'b0 || out !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet cyc=%0d out=%b out_chg=%b want 0/0", i, out, out_chg);
            end
        end
    endtask

    task automatic test_clean_press();
        mode = 2'b00;
        sw   = 3'b001;           // set up before edge k
        idle(4);                 // edges k..k+3
        n_checks++;
        if (sw_db !== 3'b000) begin n_fail++; $display("FAIL press_early_sw_db got=%b want=000", sw_db); end
        tick();                  // edge k+4
        n_checks++;
        if (sw_db !== 3'b000) begin n_fail++; $display("FAIL press_k4_sw_db got=%b want=000", sw_db); end
        tick();                  // edge k+5
        n_checks++;
        if (sw_db !== 3'b001) begin n_fail++; $display("FAIL press_k5_sw_db got=%b want=001", sw_db); end
        n_checks++;
        if (out !== 1'b0) begin n_fail++; $display("FAIL press_k5_out got=%b want=0", out); end
        tick();                  // edge k+6
        n_checks++;
        if (out !== 1'b1 || out_chg !== 1'b1) begin
            n_fail++; $display("FAIL press_k6 out=%b out_chg=%b want 1/1", out, out_chg);
        end
        tick();                  // edge k+7
        n_checks++;
        if (out !== 1'b1 || out_chg !== 1'b0) begin
            n_fail++; $display("FAIL press_k7 out=%b out_chg=%b want 1/0", out, out_chg);
        end
        sw = 3'b000;
        idle(10);
        n_checks++;
        if (sw_db !== 3'b000 || out !== 1'b0) begin
            n_fail++; $display("FAIL press_release sw_db=%b out=%b want 000/0", sw_db, out);
        end
    endtask

    task automatic test_glitch();
        mode = 2'b00;
        // (a) three-cycle pulse: reaches count 3 but never the accepting edge.
        sw = 3'b001;
        idle(3);
        sw = 3'b000;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (sw_db !== 3'b000 || out !== 1'b0 || out_chg !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_pulse cyc=%0d sw_db=%b out=%b out_chg=%b want 000/0/0",
                         i, sw_db, out, out_chg);
            end
        end
        // (b) pin toggling every cycle.
        for (int i = 0; i < 50; i++) begin
            sw = (i % 2 == 0) ? 3'b001 : 3'b000;
            tick();
            n_checks++;
            if (sw_db !== 3'b000 || out !== 1'b0 || out_chg !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_toggle cyc=%0d sw_db=%b out=%b out_chg=%b want 000/0/0",
                         i, sw_db, out, out_chg);
            end
        end
        sw = 3'b000;
        idle(8);
    endtask

    task automatic sweep(input logic [2:0] pattern, input logic [3:0] exp_out,
                         input logic [3:0] exp_chg);
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            tick();
            n_checks++;
            if (out !== exp_out[m] || out_chg !== exp_chg[m]) begin
                n_fail++;
                $display("FAIL sweep_%b_mode%0d out=%b out_chg=%b want %b/%b",
                         pattern, m, out, out_chg, exp_out[m], exp_chg[m]);
            end
            for (int j = 0; j < 3; j++) begin
                tick();
                n_checks++;
                if (out !== exp_out[m] || out_chg !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep_%b_hold%0d out=%b out_chg=%b want %b/0",
                             pattern, m, out, out_chg, exp_out[m]);
                end
            end
        end
    endtask

    task automatic test_mode_sweep();
        mode = 2'b00;
        sw   = 3'b011;
        idle(10);
        n_checks++;
        if (sw_db !== 3'b011 || out !== 1'b1) begin
            n_fail++; $display("FAIL sweep_setup_011 sw_db=%b out=%b want 011/1", sw_db, out);
        end
        // OR=1, AND=0, XOR=0, MAJ=1; pulses on 00->01 and 10->11 only.
        sweep(3'b011, 4'b1001, 4'b1010);
        sw = 3'b111;             // mode stays 11: majority already 1
        idle(10);
        n_checks++;
        if (sw_db !== 3'b111 || out !== 1'b1) begin
            n_fail++; $display("FAIL sweep_setup_111 sw_db=%b out=%b want 111/1", sw_db, out);
        end
        sweep(3'b111, 4'b1111, 4'b0000);
        mode = 2'b00;
        sw   = 3'b000;
        idle(10);
    endtask

    task automatic test_reset_mid();
        mode = 2'b00;
        sw   = 3'b100;           // set up before edge k
        idle(4);                 // edges k..k+3: channel-2 counter now 2
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (sw_db !== 3'b000 || out !== 1'b0) begin
            n_fail++; $display("FAIL midrst_in_reset sw_db=%b out=%b want 000/0", sw_db, out);
        end
        tick();
        n_checks++;
        if (sw_db !== 3'b000) begin n_fail++; $display("FAIL midrst_held sw_db=%b want=000", sw_db); end
        rst = 1'b0;              // released before edge r
        idle(5);                 // edges r..r+4
        n_checks++;
        if (sw_db !== 3'b000) begin n_fail++; $display("FAIL midrst_r4 sw_db=%b want=000", sw_db); end
        tick();                  // edge r+5
        n_checks++;
        if (sw_db !== 3'b100) begin n_fail++; $display("FAIL midrst_r5 sw_db=%b want=100", sw_db); end
        tick();
        n_checks++;
        if (out !== 1'b1 || out_chg !== 1'b1) begin
            n_fail++; $display("FAIL midrst_out out=%b out_chg=%b want 1/1", out, out_chg);
        end
        sw = 3'b000;
        idle(10);
    endtask

    task automatic test_simultaneous();
        int pulses;
        mode = 2'b11;
        idle(2);
        sw = 3'b110;
        idle(5);                 // edges k..k+4
        n_checks++;
        if (sw_db !== 3'b000) begin n_fail++; $display("FAIL simul_k4 sw_db=%b want=000", sw_db); end
        tick();                  // edge k+5
        n_checks++;
        if (sw_db !== 3'b110) begin n_fail++; $display("FAIL simul_k5 sw_db=%b want=110", sw_db); end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_chg === 1'b1) pulses++;
            if (i == 0) begin
                n_checks++;
                if (out !== 1'b1 || out_chg !== 1'b1) begin
                    n_fail++; $display("FAIL simul_k6 out=%b out_chg=%b want 1/1", out, out_chg);
                end
            end
        end
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL simul_pulses got=%0d want=1", pulses); end
        n_checks++;
        if (out !== 1'b1) begin n_fail++; $display("FAIL simul_final_out got=%b want=1", out); end
    endtask

    initial begin
        rst  = 1'b1;
        sw   = '0;
        mode = 2'b00;
        test_reset();
        test_clean_press();
        test_glitch();
        test_mode_sweep();
        test_reset_mid();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_logic_db.md
# led_logic_db

Parametrised switch-to-LED logic block. It takes `N_SW` raw slide-switch inputs and passes each through a two-flop synchroniser and a per-channel debouncer. It then combines the debounced switches with a runtime-selectable function (OR, AND, XOR, majority) and drives one registered LED output plus a one-cycle change pulse. It sits directly between the board switch pins and the LED pins, and replaces the fixed 3-input combinational OR.

## Interface
Parameters:
- `N_SW`, 3, number of switch channels; legal range 2..16.
- `DB_CYCLES`, 4, consecutive stable synchronised cycles required to accept a new switch level; legal range ≥1. Counter width is `$clog2(DB_CYCLES+1)`, computed internally.

Ports:
- `clk`  in  1  single system clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sw`  in  N_SW  raw switch levels, asynchronous to `clk`.
- `mode`  in  2  function select: 00 OR, 01 AND, 10 XOR, 11 majority. Synchronous to `clk`.
- `sw_db`  out  N_SW  debounced switch levels, registered.
- `out`  out  1  LED drive, registered.
- `out_chg`  out  1  single-cycle pulse in the cycle `out` takes a new value.

## Operation
- **Reset (async, immediate):**
  - sync stage 1 = 0, sync stage 2 = 0, all counters = 0.
  - `sw_db` = 0, `out` = 0, `out_chg` = 0.
  - Every mode evaluates to 0 on all-zero inputs, so reset release never causes a spurious `out_chg`.
- **Synchroniser:** two flops per channel. Only stage 2 (`s2`) feeds the debouncer.
- **Debouncer, per channel, independent.** Evaluated each edge:
  - `s2 == sw_db[i]`: counter cleared to 0.
  - `s2 != sw_db[i]` and counter < DB_CYCLES-1: counter increments.
  - `s2 != sw_db[i]` and counter == DB_CYCLES-1: `sw_db[i]` takes `s2`; counter clears.
  - Any return of `s2` to the old level before acceptance restarts the count from 0.
- **Combine function** (`f`, on `sw_db` and current `mode`):
  - OR: |sw_db.
  - AND: &sw_db.
  - XOR: ^sw_db.
  - Majority: 1 if 2·popcount(sw_db) > N_SW. For even N_SW, a tie gives 0.
  - The popcount width is `$clog2(N_SW+1)`; it must not overflow.
- **Output register:**
  - `out` loads `f` every edge.
  - `out_chg` loads (`f` != `out`) every edge, so it is high for exactly the cycle in which `out` holds its new value.
- No other state. No FSM beyond the per-channel debounce counters.

## Timing
- Switch edge to `sw_db`: the level is set up before edge k.
  - Sync stage 1 captures it at k; `s2` captures it at k+1.
  - `sw_db` updates at edge k+1+DB_CYCLES, provided `sw` stays stable throughout.
- `sw_db` to `out` / `out_chg`: 1 edge. Total switch-to-LED latency is DB_CYCLES+2 edges.
- `mode` change at edge m: `out` reflects the new function at edge m+1.
- Pulse rejection: a pulse on `sw` that is stable for fewer than DB_CYCLES synchronised cycles never reaches `sw_db`. A pin toggling every cycle is never accepted.
- Simultaneous events:
  - Several channels settling in the same cycle update `sw_db` in the same edge and produce one `out` update.
  - A `mode` change and a `sw_db` change in the same cycle are both folded into the next `out`. `out_chg` fires only if the net value differs.
- Reset mid-debounce: counters clear immediately. After release, a full DB_CYCLES stable window is needed again.
- Counter never exceeds DB_CYCLES-1. With DB_CYCLES=1, a new level is accepted on the first differing `s2` sample.

## Test plan
All scenarios use N_SW=3, DB_CYCLES=4.

1. **Reset:**
   - Stimulus: hold `rst`=1 with `sw`=111, `mode`=00; then release `rst` with `sw`=000.
   - Required: while in reset, `sw_db`=000, `out`=0, `out_chg`=0. No `out_chg` after release.
2. **Clean press:**
   - Stimulus: `mode`=00; set `sw`=001 before edge k and hold.
   - Required: `sw_db`=001 at edge k+5. `out`=1 and `out_chg`=1 at edge k+6. `out_chg`=0 at k+7.
3. **Glitch rejection:**
   - Stimulus (a): `sw0` high for 3 cycles, then low.
   - Stimulus (b): `sw0` toggling every cycle for 50 cycles.
   - Required: in both cases `sw_db` stays 000, `out` stays 0, `out_chg` never asserts.
4. **Mode sweep:**
   - Stimulus: with `sw_db`=011 settled, step `mode` 00, 01, 10, 11, one per 4 cycles.
   - Required: `out` = 1, 0, 0, 1, each 1 edge after the `mode` change. `out_chg` pulses at the 00→01 and 10→11 steps only.
   - Repeat with `sw_db`=111: required `out` = 1, 1, 1, 1.
5. **Reset mid-debounce:**
   - Stimulus: drive `sw`=100, and assert `rst` asynchronously (mid-cycle) when the channel-2 counter is 2; release `rst` and keep `sw`=100.
   - Required: `sw_db` remains 000 through the reset. After release, `sw_db`=100 only after the full 2+4 edges.
6. **Simultaneous channels:**
   - Stimulus: `mode`=11; `sw` goes 000→110 in one cycle.
   - Required: `sw_db` goes 000→110 in a single edge. `out` goes 0→1 with exactly one `out_chg` pulse.
